vld_writeback_seq: RTL

Load write-back sequencer for the vector load path. It accepts DMA read-data beats for one vector load instruction, packs them into full VLEN-wide register images, and issues one vector-register-file write per destination register. It also drives the `init`/`updateAddr` controls of the downstream load-slot address register and consumes its `ldAddr` as the write address, so destination registers advance vd, vd+1, … for LMUL > 1.

---
 rtl/vld_writeback_seq_pkg.sv | 21 ++
 rtl/vld_writeback_seq_beat_packer.sv | 49 ++++
 rtl/vld_writeback_seq.sv | 93 +++++++++
 3 files changed

// File: rtl/vld_writeback_seq_pkg.sv
// Shared types and size helpers for the vector-load write-back path.
// Beat counts derive from VLEN and the DMA beat width at elaboration time.
package rvvLitePkg;

    typedef enum logic [1:0] {
        LD_WB_IDLE    = 2'd0,
        LD_WB_COLLECT = 2'd1,
        LD_WB_WRITE   = 2'd2,
        LD_WB_DONE    = 2'd3
    } ld_wb_state_t;

    function automatic int calc_beats(input int vlen, input int data_width);
        return vlen / data_width;
    endfunction

    // A single-beat configuration still needs a one-bit counter.
    function automatic int calc_beat_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/vld_writeback_seq_beat_packer.sv
// Beat counter plus packing buffer: assembles DMA beats into one VLEN-wide
// register image, beat 0 in the least-significant slice.
module vld_beat_packer
    import rvvLitePkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VLEN       = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  accept,
    input  logic [DATA_WIDTH-1:0] beat_data,
    output logic                  last_beat,
    output logic [VLEN-1:0]       image
);

    localparam int BEATS = calc_beats(VLEN, DATA_WIDTH);
    localparam int CW    = calc_beat_cnt_w(BEATS);

    logic [CW-1:0]   beat_cnt_r;
    logic [VLEN-1:0] buf_r;

    assign last_beat = (beat_cnt_r == CW'(BEATS - 1));
    assign image     = buf_r;

    // Beat counter: advances per accepted beat, wraps after the last slice.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            beat_cnt_r <= {CW{1'b0}};
        end else if (accept) begin
            beat_cnt_r <= last_beat ? {CW{1'b0}} : beat_cnt_r + CW'(1);
        end
    end

    // Packing buffer: the accepted beat lands in the slice chosen by the counter.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            buf_r <= {VLEN{1'b0}};
        end else if (accept) begin
            for (int i = 0; i < BEATS; i++) begin
                if (beat_cnt_r == CW'(i)) begin
                    buf_r[i*DATA_WIDTH +: DATA_WIDTH] <= beat_data;
                end
            end
        end
    end

endmodule

// File: rtl/vld_writeback_seq.sv
// Load write-back sequencer: collects DMA beats per destination register and
// issues one VRF write per register, stepping the load-slot address between writes.
module vld_writeback_seq
    import rvvLitePkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VLEN       = 128,
    parameter int ADDR_WIDTH = 5,
    parameter int NREG_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NREG_WIDTH-1:0] num_regs,
    output logic                  init,
    output logic                  update_addr,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic                  beat_valid,
    output logic                  beat_ready,
    input  logic [DATA_WIDTH-1:0] beat_data,
    output logic                  vrf_we,
    output logic [ADDR_WIDTH-1:0] vrf_waddr,
    output logic [VLEN-1:0]       vrf_wdata,
    output logic                  busy,
    output logic                  done
);

    ld_wb_state_t          state_r;
    logic [NREG_WIDTH-1:0] reg_cnt_r;
    logic                  clr_s;
    logic                  accept_s;
    logic                  last_beat_s;
    logic [VLEN-1:0]       image_s;

    assign clr_s    = (state_r == LD_WB_IDLE) && start;
    assign accept_s = (state_r == LD_WB_COLLECT) && beat_valid;

    vld_beat_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .VLEN       (VLEN)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_s),
        .accept    (accept_s),
        .beat_data (beat_data),
        .last_beat (last_beat_s),
        .image     (image_s)
    );

    // Sequencer FSM and remaining-register counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= LD_WB_IDLE;
            reg_cnt_r <= {NREG_WIDTH{1'b0}};
        end else begin
            case (state_r)
                LD_WB_IDLE: begin
                    if (start) begin
                        reg_cnt_r <= num_regs;
                        state_r   <= (num_regs == {NREG_WIDTH{1'b0}}) ? LD_WB_DONE : LD_WB_COLLECT;
                    end
                end
                LD_WB_COLLECT: begin
                    if (accept_s && last_beat_s) begin
                        state_r <= LD_WB_WRITE;
                    end
                end
                LD_WB_WRITE: begin
                    reg_cnt_r <= reg_cnt_r - NREG_WIDTH'(1);
                    state_r   <= (reg_cnt_r == NREG_WIDTH'(1)) ? LD_WB_DONE : LD_WB_COLLECT;
                end
                LD_WB_DONE: begin
                    state_r <= LD_WB_IDLE;
                end
                default: begin
                    state_r <= LD_WB_IDLE;
                end
            endcase
        end
    end

    // init must reach the load-slot in the start cycle, so it is not registered.
    assign init        = clr_s;
    assign beat_ready  = (state_r == LD_WB_COLLECT);
    assign vrf_we      = (state_r == LD_WB_WRITE);
    assign update_addr = (state_r == LD_WB_WRITE);
    assign vrf_waddr   = ld_addr;
    assign vrf_wdata   = image_s;
    assign busy        = (state_r != LD_WB_IDLE);
    assign done        = (state_r == LD_WB_DONE);

endmodule
